pio_event_sequencer: RTL and testbench



---
 rtl/pio_event_pkg.sv | 27 ++
 rtl/pio_event_fifo.sv | 49 ++++
 rtl/pio_event_sequencer.sv | 117 +++++++++++
 tb/tb_pio_event_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_event_pkg.sv
// Shared types and constants for the PIO edge-capture event sequencer.
package pio_event_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRdAddr,
    StRdWait,
    StClr,
    StDispatch
  } state_e;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  // Index of the least-significant set bit; 0 when v is zero.
  function automatic logic [2:0] lowest_set_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pio_event_fifo.sv
// Show-ahead event FIFO; a push into a full FIFO is still taken if the head pops that cycle.
module pio_event_fifo #(
  parameter int unsigned DW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, do_pop, do_push;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_MAX);
    valid   = !empty;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    data    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pio_event_sequencer.sv
// Services the button PIO's edge-capture interrupt over Avalon-MM and queues one event per
// captured bit as a button index.
module pio_event_sequencer
  import pio_event_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic [7:0]  MASK_INIT  = 8'hFF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        irq_in,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        evt_valid,
  output logic [2:0]  evt_code,
  input  logic        evt_ready,
  output logic        overflow,
  input  logic        ovf_clear
);

  state_e     state;
  logic [7:0] cap, cap_next, rd_cap;
  logic       push, fifo_full, drop;
  logic       unused_rd;

  assign unused_rd = ^avm_readdata;

  always_comb begin
    rd_cap             = '0;
    rd_cap[WIDTH-1:0]  = avm_readdata[WIDTH-1:0];
    cap_next           = cap & (cap - 8'd1);
    push               = (state == StDispatch) && (cap != '0);
    drop               = push && fifo_full && !(evt_valid && evt_ready);
  end

  // Bus outputs are registered together with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StInit;
      cap            <= '0;
      avm_address    <= PIO_ADDR_DATA;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      avm_address    <= PIO_ADDR_DATA;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      case (state)
        StInit: begin
          avm_address    <= PIO_ADDR_MASK;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= {24'd0, MASK_INIT};
          state          <= StIdle;
        end
        StIdle: begin
          if (irq_in && enable) begin
            avm_address    <= PIO_ADDR_EDGE;
            avm_chipselect <= 1'b1;
            state          <= StRdAddr;
          end
        end
        StRdAddr: begin
          avm_address <= PIO_ADDR_EDGE;
          state       <= StRdWait;
        end
        StRdWait: begin
          cap <= rd_cap;
          if (rd_cap == '0) begin
            state <= StIdle;
          end else begin
            // Clear only what was read so later edges stay captured in the PIO.
            avm_address    <= PIO_ADDR_EDGE;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= {24'd0, rd_cap};
            state          <= StClr;
          end
        end
        StClr: state <= StDispatch;
        StDispatch: begin
          cap <= cap_next;
          if (cap_next == '0) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

  pio_event_fifo #(
    .DW    (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (lowest_set_index(cap)),
    .pop       (evt_ready),
    .valid     (evt_valid),
    .data      (evt_code),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_pio_event_sequencer.sv
// Directed bench for pio_event_sequencer with a small behavioural model of the button PIO.
module tb_pio_event_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, irq_in, evt_ready, ovf_clear, evt_valid, overflow;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic [2:0]  evt_code;

  logic [7:0]  edge_cap = '0;
  logic [7:0]  mask;
  logic [7:0]  edge_in = '0;
  logic        force_irq = 1'b0;
  int          write_count = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pio_event_sequencer #(
    .WIDTH      (8),
    .MASK_INIT  (8'hFF),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .irq_in         (irq_in),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .evt_valid      (evt_valid),
    .evt_code       (evt_code),
    .evt_ready      (evt_ready),
    .overflow       (overflow),
    .ovf_clear      (ovf_clear)
  );

  // PIO model: mask cleared by reset, edge capture survives it, readdata registered.
  assign irq_in = (|(edge_cap & mask)) | force_irq;

  always @(posedge clk or posedge reset) begin
    if (reset) mask <= '0;
    else if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask <= avm_writedata[7:0];
  end

  always @(posedge clk) begin
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
      edge_cap <= (edge_cap & ~avm_writedata[7:0]) | edge_in;
    else
      edge_cap <= edge_cap | edge_in;
    avm_readdata <= (avm_address == 2'd3) ? {24'd0, edge_cap} : 32'd0;
    if (avm_chipselect && !avm_write_n) write_count <= write_count + 1;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; evt_ready = 1'b0; ovf_clear = 1'b0;
    tick(3);
    checks++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_bus got=%b_%b_%0d_%h exp=0_1_0_00000000", avm_chipselect, avm_write_n,
               avm_address, avm_writedata);
    end
    checks++;
    if ({evt_valid, evt_code, overflow} !== 5'b0) begin
      failures++;
      $display("FAIL reset_evt got=%b_%0d_%b exp=0_0_0", evt_valid, evt_code, overflow);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 2'd2, 32'hFF}) begin
      failures++;
      $display("FAIL init_write got=%b_%b_%0d_%h exp=1_0_2_000000ff", avm_chipselect, avm_write_n,
               avm_address, avm_writedata);
    end
    tick();
    checks++;
    if ({avm_chipselect, avm_write_n, evt_valid, overflow, mask} !== {4'b0100, 8'hFF}) begin
      failures++;
      $display("FAIL post_init got=cs%b wn%b v%b ov%b mask%h exp=cs0 wn1 v0 ov0 maskff",
               avm_chipselect, avm_write_n, evt_valid, overflow, mask);
    end
  endtask

  task automatic test_basic;
    edge_in = 8'h05;
    tick();
    edge_in = 8'h00;
    tick();  // RD_ADDR
    checks++;
    if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL basic_read got=cs%b wn%b a%0d exp=cs1 wn1 a3", avm_chipselect, avm_write_n,
               avm_address);
    end
    tick(2);  // CLR
    checks++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 2'd3, 32'h5}) begin
      failures++;
      $display("FAIL basic_clear got=%b_%b_%0d_%h exp=1_0_3_00000005", avm_chipselect,
               avm_write_n, avm_address, avm_writedata);
    end
    tick();  // DISPATCH, before first push
    checks++;
    if ({irq_in, evt_valid} !== 2'b00) begin
      failures++;
      $display("FAIL basic_pre_push got=irq%b v%b exp=irq0 v0", irq_in, evt_valid);
    end
    tick();  // cycle k+4
    checks++;
    if ({evt_valid, evt_code} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL basic_first got=v%b c%0d exp=v1 c0", evt_valid, evt_code);
    end
    tick();
    evt_ready = 1'b1;
    tick();
    checks++;
    if ({evt_valid, evt_code} !== {1'b1, 3'd2}) begin
      failures++;
      $display("FAIL basic_second got=v%b c%0d exp=v1 c2", evt_valid, evt_code);
    end
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drained got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_late_edge;
    logic [2:0] exp_codes [3];
    exp_codes[0] = 3'd0; exp_codes[1] = 3'd2; exp_codes[2] = 3'd6;
    edge_in = 8'h05;
    tick();
    edge_in = 8'h00;
    tick(2);  // RD_WAIT: bit 6 arrives after the read
    edge_in = 8'h40;
    tick();
    edge_in = 8'h00;
    checks++;
    if (avm_writedata !== 32'h5 || avm_write_n !== 1'b0) begin
      failures++;
      $display("FAIL late_clear got=wn%b d%h exp=wn0 d00000005", avm_write_n, avm_writedata);
    end
    tick();
    checks++;
    if (irq_in !== 1'b1 || edge_cap !== 8'h40) begin
      failures++;
      $display("FAIL late_kept got=irq%b cap%h exp=irq1 cap40", irq_in, edge_cap);
    end
    tick(12);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({evt_valid, evt_code} !== {1'b1, exp_codes[i]}) begin
        failures++;
        $display("FAIL late_code%0d got=v%b c%0d exp=v1 c%0d", i, evt_valid, evt_code,
                 exp_codes[i]);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    checks++;
    if ({evt_valid, irq_in} !== 2'b00) begin
      failures++;
      $display("FAIL late_done got=v%b irq%b exp=v0 irq0", evt_valid, irq_in);
    end
  endtask

  task automatic test_spurious;
    int wc0;
    wc0 = write_count;
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    checks++;
    if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL spur_read got=cs%b wn%b a%0d exp=cs1 wn1 a3", avm_chipselect, avm_write_n,
               avm_address);
    end
    tick(2);  // back in IDLE at k+3
    checks++;
    if ({avm_chipselect, avm_write_n, avm_address} !== {1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL spur_idle got=cs%b wn%b a%0d exp=cs0 wn1 a0", avm_chipselect, avm_write_n,
               avm_address);
    end
    tick(4);
    checks++;
    if (write_count !== wc0 || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL spur_nowrite got=w%0d v%b exp=w%0d v0", write_count, evt_valid, wc0);
    end
  endtask

  task automatic test_enable;
    int wc0;
    wc0 = write_count;
    enable = 1'b0;
    edge_in = 8'h01;
    tick();
    edge_in = 8'h00;
    tick(6);
    checks++;
    if ({irq_in, evt_valid} !== 2'b10 || write_count !== wc0) begin
      failures++;
      $display("FAIL en_hold got=irq%b v%b w%0d exp=irq1 v0 w%0d", irq_in, evt_valid,
               write_count, wc0);
    end
    enable = 1'b1;
    tick(8);
    checks++;
    if ({evt_valid, evt_code, irq_in} !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL en_serviced got=v%b c%0d irq%b exp=v1 c0 irq0", evt_valid, evt_code, irq_in);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow;
    edge_in = 8'h3F;
    tick();
    edge_in = 8'h00;
    tick(16);
    checks++;
    if ({overflow, evt_valid, evt_code} !== {2'b11, 3'd0}) begin
      failures++;
      $display("FAIL ovf_set got=ov%b v%b c%0d exp=ov1 v1 c0", overflow, evt_valid, evt_code);
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({evt_valid, evt_code} !== {1'b1, 3'(i)}) begin
        failures++;
        $display("FAIL ovf_code%0d got=v%b c%0d exp=v1 c%0d", i, evt_valid, evt_code, i);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drained got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_reset_mid;
    int wc0;
    edge_in = 8'hF0;
    tick();
    edge_in = 8'h00;
    tick(5);  // cycle k+4: one event pushed
    checks++;
    if ({evt_valid, evt_code} !== {1'b1, 3'd4}) begin
      failures++;
      $display("FAIL rmid_push got=v%b c%0d exp=v1 c4", evt_valid, evt_code);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({evt_valid, evt_code, overflow, avm_chipselect, avm_write_n, avm_address} !==
        {1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL rmid_reset got=v%b c%0d ov%b cs%b wn%b a%0d exp=v0 c0 ov0 cs0 wn1 a0",
               evt_valid, evt_code, overflow, avm_chipselect, avm_write_n, avm_address);
    end
    tick(2);
    reset = 1'b0;
    wc0 = write_count;
    tick();
    checks++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 2'd2, 32'hFF}) begin
      failures++;
      $display("FAIL rmid_mask got=%b_%b_%0d_%h exp=1_0_2_000000ff", avm_chipselect, avm_write_n,
               avm_address, avm_writedata);
    end
    tick(12);
    checks++;
    if (evt_valid !== 1'b0 || write_count !== wc0 + 1 || mask !== 8'hFF) begin
      failures++;
      $display("FAIL rmid_stale got=v%b w%0d m%h exp=v0 w%0d mff", evt_valid, write_count, mask,
               wc0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_late_edge();
    test_spurious();
    test_enable();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
